// File: rtl/onehot_encoder_8to3.sv
// Registered 8-to-3 priority encoder with any-active (valid) and multi-hot (err) flags.
// MSB_PRIORITY selects whether the highest or the lowest set request wins on a collision.
module onehot_encoder_8to3 #(
  parameter bit MSB_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] D,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       valid,
  output logic       err
);

  logic [2:0] idx;
  logic       any;
  logic       multi;

  always_comb begin
    idx = '0;
    if (MSB_PRIORITY) begin
      // Ascending scan: the last set bit seen (the highest) wins.
      for (int unsigned i = 0; i < 8; i++) begin
        if (D[i]) idx = 3'(i);
      end
    end else begin
      // Descending scan: the last set bit seen (the lowest) wins.
      for (int unsigned i = 8; i > 0; i--) begin
        if (D[i-1]) idx = 3'(i - 1);
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign any   = |D;
  assign multi = |(D & (D - 8'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      X     <= 1'b0;
      Y     <= 1'b0;
      Z     <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      X     <= idx[2];
      Y     <= idx[1];
      Z     <= idx[0];
      valid <= any;
      err   <= multi;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Directed bench for onehot_encoder_8to3: one instance per priority setting, shared stimulus.
module tb_onehot_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic       hx, hy, hz, hv, he;
  logic       lx, ly, lz, lv, le;
  logic [4:0] hi_o, lo_o;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  onehot_encoder_8to3 #(.MSB_PRIORITY(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .D(d),
    .X(hx), .Y(hy), .Z(hz), .valid(hv), .err(he)
  );

  onehot_encoder_8to3 #(.MSB_PRIORITY(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .D(d),
    .X(lx), .Y(ly), .Z(lz), .valid(lv), .err(le)
  );

  // Packed view: {X,Y,Z,valid,err}
  assign hi_o = {hx, hy, hz, hv, he};
  assign lo_o = {lx, ly, lz, lv, le};

  task automatic step(input logic [7:0] dv, input logic rv);
    d     = dv;
    rst_n = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      step(8'hFF, 1'b0);
      total++;
      if (hi_o !== 5'b00000) $display("FAIL reset_hi cyc%0d: got %b expected %b", n, hi_o, 5'b00000);
      else passed++;
      total++;
      if (lo_o !== 5'b00000) $display("FAIL reset_lo cyc%0d: got %b expected %b", n, lo_o, 5'b00000);
      else passed++;
    end
    step(8'b1000_0000, 1'b1);
    total++;
    if (hi_o !== 5'b11110) $display("FAIL release_hi: got %b expected %b", hi_o, 5'b11110);
    else passed++;
    total++;
    if (lo_o !== 5'b11110) $display("FAIL release_lo: got %b expected %b", lo_o, 5'b11110);
    else passed++;
  endtask

  task automatic test_onehot_sweep();
    logic [7:0] v;
    logic [4:0] e;
    for (int i = 0; i < 8; i++) begin
      v = 8'd1 << i;
      e = {3'(i), 1'b1, 1'b0};
      step(v, 1'b1);
      total++;
      if (hi_o !== e) $display("FAIL sweep_hi D=%b: got %b expected %b", v, hi_o, e);
      else passed++;
      total++;
      if (lo_o !== e) $display("FAIL sweep_lo D=%b: got %b expected %b", v, lo_o, e);
      else passed++;
    end
  endtask

  task automatic test_zero();
    step(8'h00, 1'b1);
    total++;
    if (hi_o !== 5'b00000) $display("FAIL zero_hi: got %b expected %b", hi_o, 5'b00000);
    else passed++;
    total++;
    if (lo_o !== 5'b00000) $display("FAIL zero_lo: got %b expected %b", lo_o, 5'b00000);
    else passed++;
    step(8'h01, 1'b1);
    total++;
    if (hi_o !== 5'b00010) $display("FAIL bit0_hi: got %b expected %b", hi_o, 5'b00010);
    else passed++;
    total++;
    if (lo_o !== 5'b00010) $display("FAIL bit0_lo: got %b expected %b", lo_o, 5'b00010);
    else passed++;
  endtask

  task automatic test_multi_hot();
    logic [7:0] vec [4] = '{8'b0010_0100, 8'hFF, 8'b1000_0001, 8'b0001_1000};
    logic [4:0] ehi [4] = '{5'b10111, 5'b11111, 5'b11111, 5'b10011};
    logic [4:0] elo [4] = '{5'b01011, 5'b00011, 5'b00011, 5'b01111};
    for (int k = 0; k < 4; k++) begin
      step(vec[k], 1'b1);
      total++;
      if (hi_o !== ehi[k]) $display("FAIL multi_hi D=%b: got %b expected %b", vec[k], hi_o, ehi[k]);
      else passed++;
      total++;
      if (lo_o !== elo[k]) $display("FAIL multi_lo D=%b: got %b expected %b", vec[k], lo_o, elo[k]);
      else passed++;
    end
  endtask

  task automatic test_hold();
    step(8'b0100_0000, 1'b1);
    d = 8'b0000_0011;
    #3;
    total++;
    if (hi_o !== 5'b11010) $display("FAIL hold_hi: got %b expected %b", hi_o, 5'b11010);
    else passed++;
    total++;
    if (lo_o !== 5'b11010) $display("FAIL hold_lo: got %b expected %b", lo_o, 5'b11010);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (hi_o !== 5'b00111) $display("FAIL after_hold_hi: got %b expected %b", hi_o, 5'b00111);
    else passed++;
    total++;
    if (lo_o !== 5'b00011) $display("FAIL after_hold_lo: got %b expected %b", lo_o, 5'b00011);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    logic [7:0] v;
    logic [4:0] e;
    for (int i = 0; i < 8; i++) begin
      v = 8'd1 << i;
      if (i == 4) begin
        step(v, 1'b0);
        e = 5'b00000;
      end else begin
        step(v, 1'b1);
        e = {3'(i), 1'b1, 1'b0};
      end
      total++;
      if (hi_o !== e) $display("FAIL midrst_hi step%0d: got %b expected %b", i, hi_o, e);
      else passed++;
      total++;
      if (lo_o !== e) $display("FAIL midrst_lo step%0d: got %b expected %b", i, lo_o, e);
      else passed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    d     = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_onehot_sweep();
    test_zero();
    test_multi_hot();
    test_hold();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
